// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   typedef struct packed {
      logic       extended;
      logic       released;
      logic [7:0] code;
   } ps2_event_t;

   localparam int EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head is always on dout.
// A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Storage array; contents need no reset because outputs are qualified by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   // Pointer/count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the PS/2 lines, frame
// 11-bit words, fold E0/F0 prefixes into flags and queue key events.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int FIFO_DEPTH     = 8,
   parameter int RAW_MODE       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic [7:0] code,
   output logic       extended,
   output logic       released,
   output logic       valid,
   input  logic       ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overflow
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic c_meta_q, c_meta_d, c_sync_q, c_sync_d;
   logic d_meta_q, d_meta_d, d_sync_q, d_sync_d;
   logic filt_q, filt_d, filt_dly_q, filt_dly_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic fall;

   rx_state_e state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    sh_q, sh_d;
   logic          perr_q, perr_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          good_byte;

   logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
   logic       push_q, push_d;
   ps2_event_t push_ev_q, push_ev_d;
   logic       parity_err_q, parity_err_d;
   logic       frame_err_q, frame_err_d;
   logic       overflow_q, overflow_d;

   logic [EVENT_W-1:0] fifo_dout;
   logic               fifo_full, fifo_empty, pop;
   logic [CW-1:0]      fifo_count_unused;
   ps2_event_t         head;

   assign fall = filt_dly_q & ~filt_q;

   // Two-flop synchronisers, then a counter that only lets the clock flip after
   // FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      c_meta_d   = ps2c;
      c_sync_d   = c_meta_q;
      d_meta_d   = ps2d;
      d_sync_d   = d_meta_q;
      filt_d     = filt_q;
      filt_dly_d = filt_q;
      fcnt_d     = '0;
      if (c_sync_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
         else                               fcnt_d = fcnt_q + FW'(1);
      end
   end

   // Frame FSM with stall timeout; error pulses are registered one cycle later.
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      sh_d         = sh_q;
      perr_d       = perr_q;
      to_cnt_d     = to_cnt_q;
      good_byte    = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      if (fall)                     to_cnt_d = '0;
      else if (state_q != ST_IDLE) to_cnt_d = to_cnt_q + TW'(1);

      if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
         state_d     = ST_IDLE;
         to_cnt_d    = '0;
         frame_err_d = 1'b1;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               // A high start bit is treated as line noise and ignored.
               if (!d_sync_q) begin
                  state_d  = ST_DATA;
                  bitcnt_d = '0;
               end
            end
            ST_DATA: begin
               sh_d     = {d_sync_q, sh_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               perr_d  = ~(^sh_q ^ d_sync_q);
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!d_sync_q)   frame_err_d  = 1'b1;
               else if (perr_q) parity_err_d = 1'b1;
               else             good_byte    = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Prefix folding: E0/F0 arm flags for the next byte, any error disarms them.
   always_comb begin
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      push_d     = 1'b0;
      push_ev_d  = '0;
      overflow_d = push_q & fifo_full & ~pop;
      if (parity_err_d || frame_err_d) begin
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
      end else if (good_byte) begin
         if (RAW_MODE != 0) begin
            push_d    = 1'b1;
            push_ev_d = '{extended: 1'b0, released: 1'b0, code: sh_q};
         end else if (sh_q == PS2_EXT) begin
            ext_pend_d = 1'b1;
         end else if (sh_q == PS2_BRK) begin
            brk_pend_d = 1'b1;
         end else begin
            push_d     = 1'b1;
            push_ev_d  = '{extended: ext_pend_q, released: brk_pend_q, code: sh_q};
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_meta_q     <= 1'b1;
         c_sync_q     <= 1'b1;
         d_meta_q     <= 1'b1;
         d_sync_q     <= 1'b1;
         filt_q       <= 1'b1;
         filt_dly_q   <= 1'b1;
         fcnt_q       <= '0;
         state_q      <= ST_IDLE;
         bitcnt_q     <= '0;
         sh_q         <= '0;
         perr_q       <= 1'b0;
         to_cnt_q     <= '0;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         push_q       <= 1'b0;
         push_ev_q    <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         c_meta_q     <= c_meta_d;
         c_sync_q     <= c_sync_d;
         d_meta_q     <= d_meta_d;
         d_sync_q     <= d_sync_d;
         filt_q       <= filt_d;
         filt_dly_q   <= filt_dly_d;
         fcnt_q       <= fcnt_d;
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         sh_q         <= sh_d;
         perr_q       <= perr_d;
         to_cnt_q     <= to_cnt_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         push_q       <= push_d;
         push_ev_q    <= push_ev_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overflow_q   <= overflow_d;
      end
   end

   assign pop = valid & ready;

   sync_fifo #(
      .WIDTH(EVENT_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push_q),
      .din  (push_ev_q),
      .pop  (pop),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count_unused)
   );

   // Head fields are forced to zero while empty so reset values are clean.
   assign head       = ps2_event_t'(fifo_dout);
   assign valid      = ~fifo_empty;
   assign code       = valid ? head.code : 8'h00;
   assign extended   = valid & head.extended;
   assign released   = valid & head.released;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: a folded-flag instance and a raw-mode instance
// share the PS/2 lines; events are checked against a spec-level model.
module tb_ps2_keyboard_rx;

   localparam int FL   = 4;
   localparam int TO   = 1000;
   localparam int FD   = 8;
   localparam int HALF = 20;

   logic clk = 1'b0, rst = 1'b1, ps2c = 1'b1, ps2d = 1'b1, ready = 1'b0;
   logic [7:0] code, r_code;
   logic extended, released, valid, parity_err, frame_err, overflow;
   logic r_ext, r_rel, r_valid, r_perr, r_ferr, r_ovf;

   ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .RAW_MODE(0)) dut (
      .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .code(code), .extended(extended),
      .released(released), .valid(valid), .ready(ready), .parity_err(parity_err),
      .frame_err(frame_err), .overflow(overflow));

   ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .RAW_MODE(1)) dut_raw (
      .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .code(r_code), .extended(r_ext),
      .released(r_rel), .valid(r_valid), .ready(1'b1), .parity_err(r_perr),
      .frame_err(r_ferr), .overflow(r_ovf));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;
   logic [9:0] got_q[$], raw_q[$], exp_q[$], raw_exp[$];
   int n_perr = 0, n_ferr = 0, n_ovf = 0, n_rperr = 0, n_rferr = 0, n_rovf = 0;
   int e_perr = 0, e_ferr = 0, e_ovf = 0;
   bit m_ext = 0, m_brk = 0;
   int r_valid_cyc = 0, stop_cyc = 0;
   bit stop_flag = 0;
   bit rnd_en = 0;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) got_q.push_back({extended, released, code});
         if (r_valid) begin
            raw_q.push_back({r_ext, r_rel, r_code});
            r_valid_cyc = cyc;
         end
         if (parity_err) n_perr++;
         if (frame_err)  n_ferr++;
         if (overflow)   n_ovf++;
         if (r_perr)     n_rperr++;
         if (r_ferr)     n_rferr++;
         if (r_ovf)      n_rovf++;
      end
   end

   // Random back-pressure for the randomized section.
   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One PS/2 frame, optionally truncated to nedges falling edges, optionally
   // with one-cycle glitches in the middle of every clock phase.
   task automatic send_byte(input logic [7:0] b, input bit fp, input bit bs,
                            input int nedges = 11, input bit glitch = 0);
      logic [10:0] fr;
      fr = {~bs, (~^b) ^ fp, b, 1'b0};
      for (int i = 0; i < nedges; i++) begin
         ps2d = fr[i];
         tick(HALF);
         if (i == 10) begin
            stop_cyc  = cyc;
            stop_flag = 1;
         end
         ps2c = 1'b0;
         if (glitch) begin
            tick(HALF / 2); ps2c = 1'b1; tick(1); ps2c = 1'b0; tick(HALF / 2 - 1);
         end else tick(HALF);
         ps2c = 1'b1;
         if (glitch) begin
            tick(HALF / 2); ps2c = 1'b0; tick(1); ps2c = 1'b1; tick(HALF / 2 - 1);
         end else tick(HALF);
      end
      ps2d = 1'b1;
   endtask

   // Reference: what the keyboard stream means, straight from the framing rules.
   task automatic model_frame(input logic [7:0] b, input bit fp, input bit bs);
      if (bs) begin
         e_ferr++; m_ext = 0; m_brk = 0;
      end else if (fp) begin
         e_perr++; m_ext = 0; m_brk = 0;
      end else begin
         raw_exp.push_back({2'b00, b});
         if (b == 8'hE0)      m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            exp_q.push_back({m_ext, m_brk, b});
            m_ext = 0; m_brk = 0;
         end
      end
   endtask

   task automatic cmp_events(input string nm);
      chk({nm, " count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s ev%0d", nm, i), got_q[i], exp_q[i]);
      chk({nm, " raw count"}, raw_q.size(), raw_exp.size());
      for (int i = 0; i < raw_q.size() && i < raw_exp.size(); i++)
         chk($sformatf("%s raw%0d", nm, i), raw_q[i], raw_exp[i]);
      got_q.delete(); exp_q.delete(); raw_q.delete(); raw_exp.delete();
      chk({nm, " parity_err"}, n_perr, e_perr);
      chk({nm, " frame_err"}, n_ferr, e_ferr);
      chk({nm, " overflow"}, n_ovf, e_ovf);
      chk({nm, " raw parity_err"}, n_rperr, e_perr);
      chk({nm, " raw frame_err"}, n_rferr, e_ferr);
      chk({nm, " raw overflow"}, n_rovf, 0);
   endtask

   typedef struct {
      logic [7:0] b;
      bit         fp;
      bit         bs;
      int         n;
      logic [9:0] ev;
      int         dp;
      int         df;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int lat, p0, f0;
      logic [7:0] rb;
      bit fp, bs;

      tbl[0]  = '{8'h1C, 0, 0, 1, 10'h01C, 0, 0};
      tbl[1]  = '{8'h1C, 1, 0, 0, 10'h000, 1, 0};
      tbl[2]  = '{8'hF0, 0, 0, 0, 10'h000, 0, 0};
      tbl[3]  = '{8'h1C, 0, 0, 1, 10'h11C, 0, 0};
      tbl[4]  = '{8'hF0, 1, 0, 0, 10'h000, 1, 0};
      tbl[5]  = '{8'h1C, 0, 0, 1, 10'h01C, 0, 0};
      tbl[6]  = '{8'hE0, 0, 0, 0, 10'h000, 0, 0};
      tbl[7]  = '{8'hF0, 0, 0, 0, 10'h000, 0, 0};
      tbl[8]  = '{8'h75, 0, 0, 1, 10'h375, 0, 0};
      tbl[9]  = '{8'hE0, 0, 0, 0, 10'h000, 0, 0};
      tbl[10] = '{8'h6B, 0, 1, 0, 10'h000, 0, 1};
      tbl[11] = '{8'h6B, 0, 0, 1, 10'h06B, 0, 0};
      tbl[12] = '{8'hFF, 0, 0, 1, 10'h0FF, 0, 0};
      tbl[13] = '{8'h00, 1, 1, 0, 10'h000, 0, 1};

      // Reset state
      tick(3);
      chk("reset valid", valid, 0);
      chk("reset code", code, 0);
      chk("reset extended", extended, 0);
      chk("reset released", released, 0);
      chk("reset parity_err", parity_err, 0);
      chk("reset frame_err", frame_err, 0);
      chk("reset overflow", overflow, 0);
      rst = 1'b0;
      tick(5);

      // Table-driven single frames
      ready = 1'b1;
      foreach (tbl[k]) begin
         p0 = n_perr; f0 = n_ferr;
         send_byte(tbl[k].b, tbl[k].fp, tbl[k].bs);
         model_frame(tbl[k].b, tbl[k].fp, tbl[k].bs);
         tick(30);
         chk($sformatf("tbl%0d count", k), got_q.size(), tbl[k].n);
         if (got_q.size() == 1 && tbl[k].n == 1)
            chk($sformatf("tbl%0d event", k), got_q[0], tbl[k].ev);
         chk($sformatf("tbl%0d parity_err", k), n_perr - p0, tbl[k].dp);
         chk($sformatf("tbl%0d frame_err", k), n_ferr - f0, tbl[k].df);
         got_q.delete(); exp_q.delete();
      end
      chk("tbl raw count", raw_q.size(), raw_exp.size());
      for (int i = 0; i < raw_q.size() && i < raw_exp.size(); i++)
         chk($sformatf("tbl raw%0d", i), raw_q[i], raw_exp[i]);
      raw_q.delete(); raw_exp.delete();

      // valid holds until ready
      ready = 1'b0;
      send_byte(8'h1C, 0, 0);
      model_frame(8'h1C, 0, 0);
      tick(30);
      chk("hold valid", valid, 1);
      chk("hold code", code, 8'h1C);
      tick(50);
      chk("hold valid late", valid, 1);
      ready = 1'b1;
      tick(1);
      chk("hold valid after pop", valid, 0);
      cmp_events("hold");

      // Stalled frame after a prefix: timeout drops the prefix
      send_byte(8'hE0, 0, 0);
      model_frame(8'hE0, 0, 0);
      send_byte(8'h29, 0, 0, 4);
      tick(TO + 50);
      e_ferr++; m_ext = 0; m_brk = 0;
      send_byte(8'h29, 0, 0);
      model_frame(8'h29, 0, 0);
      tick(30);
      cmp_events("timeout");

      // Glitches shorter than the filter
      send_byte(8'h5A, 0, 0, 11, 1);
      model_frame(8'h5A, 0, 0);
      tick(30);
      cmp_events("glitch");

      // Reset mid-frame, then a clean frame
      send_byte(8'h33, 0, 0, 5);
      rst = 1'b1; tick(2); rst = 1'b0;
      m_ext = 0; m_brk = 0;
      tick(20);
      send_byte(8'h1C, 0, 0);
      model_frame(8'h1C, 0, 0);
      tick(30);
      cmp_events("midreset");

      // FIFO_DEPTH+1 events with no consumer: last one dropped
      ready = 1'b0;
      for (int k = 0; k <= FD; k++) begin
         send_byte(8'h10 + 8'(k), 0, 0);
         model_frame(8'h10 + 8'(k), 0, 0);
      end
      tick(30);
      void'(exp_q.pop_back());
      e_ovf++;
      ready = 1'b1;
      tick(FD + 5);
      cmp_events("overflow");

      // Same, but the consumer pops in exactly the cycle of the last push
      ready = 1'b0;
      for (int k = 0; k < FD; k++) begin
         send_byte(8'h20 + 8'(k), 0, 0);
         model_frame(8'h20 + 8'(k), 0, 0);
      end
      tick(30);
      lat = r_valid_cyc - stop_cyc;
      stop_flag = 0;
      fork
         send_byte(8'h28, 0, 0);
         begin
            wait (stop_flag == 1);
            while (cyc < stop_cyc + lat - 1) tick(1);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
         end
      join
      model_frame(8'h28, 0, 0);
      tick(30);
      ready = 1'b1;
      tick(FD + 5);
      cmp_events("full_pop");

      // Randomized stream with random back-pressure
      rnd_en = 1;
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 9))
            0:       rb = 8'hE0;
            1:       rb = 8'hF0;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         fp = ($urandom_range(0, 9) == 0);
         bs = !fp && ($urandom_range(0, 14) == 0);
         send_byte(rb, fp, bs);
         model_frame(rb, fp, bs);
      end
      rnd_en = 0;
      tick(2);
      ready = 1'b1;
      tick(FD + 30);
      cmp_events("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
